// File: rtl/axi_interface_arbitrater_if.sv
// AXI3/AXI4 bus bundle between the cache arbiter and the interconnect.
//   master : the arbiter; drives AR/AW/W channels plus rready/bready.
//   slave  : the interconnect; drives the ready signals plus the R/B channels.
interface axi_interface_arbitrater_if;
  // AR channel
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  // R channel
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  // AW channel
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  // W channel
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  // B channel
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/axi_interface_arbitrater.sv
// Single-port AXI master arbitrating I-cache and D-cache requests.
// Single-beat transfers, one outstanding transaction, data side has priority.
// Ports:
//   clk, reset           : clock, async active-high reset
//   stall_by_arbitrater  : high while any cache request is still unserved
//   inst_cache_*         : instruction-side req/addr/size in, rdata/dok out
//   data_cache_*         : data-side req/addr/wr/size/wdata in, rdata/dok out
//   axi                  : AXI bus (master modport)
module axi_interface_arbitrater #(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic        clk,
  input  logic        reset,
  output logic        stall_by_arbitrater,
  input  logic        inst_cache_req,
  input  logic [31:0] inst_cache_addr,
  input  logic        inst_cache_wr,
  input  logic [1:0]  inst_cache_size,
  input  logic [31:0] inst_cache_wdata,
  output logic [31:0] inst_cache_rdata,
  output logic        inst_cache_dok,
  input  logic        data_cache_req,
  input  logic [31:0] data_cache_addr,
  input  logic        data_cache_wr,
  input  logic [1:0]  data_cache_size,
  input  logic [31:0] data_cache_wdata,
  output logic [31:0] data_cache_rdata,
  output logic        data_cache_dok,
  axi_interface_arbitrater_if.master axi
);

  typedef enum logic [2:0] {
    S_IDLE, S_I_AR, S_I_R, S_D_AR, S_D_R, S_D_AWW, S_D_B
  } state_t;

  state_t      r_state, w_next;
  logic [31:0] r_addr, r_wdata;
  logic [1:0]  r_size;
  logic        r_done_i, r_done_d;
  logic        r_aw_done, r_w_done;
  logic        r_inst_dok, r_data_dok;
  logic [31:0] r_inst_rdata, r_data_rdata;
  logic [3:0]  w_wstrb;
  logic        w_stall;

  // Inputs that carry no information for single-beat, in-order traffic.
  logic w_unused_ok;
  assign w_unused_ok = ^{inst_cache_wr, inst_cache_wdata, axi.rid, axi.rresp,
                         axi.rlast, axi.bid, axi.bresp};

  // A done flag masks its request until the cache sees the dok and the
  // stall drops; without it the still-high level req would be re-served.
  assign w_stall = (inst_cache_req & ~r_done_i) | (data_cache_req & ~r_done_d);
  assign stall_by_arbitrater = w_stall;

  assign inst_cache_dok   = r_inst_dok;
  assign data_cache_dok   = r_data_dok;
  assign inst_cache_rdata = r_inst_rdata;
  assign data_cache_rdata = r_data_rdata;

  always_comb begin
    case (r_size)
      2'b00:   w_wstrb = 4'b0001 << r_addr[1:0];
      2'b01:   w_wstrb = 4'b0011 << {r_addr[1], 1'b0};
      default: w_wstrb = 4'b1111;
    endcase
  end

  // Fixed single-beat attributes
  assign axi.arid    = (r_state == S_I_AR) ? INST_ID : DATA_ID;
  assign axi.araddr  = r_addr;
  assign axi.arlen   = 8'd0;
  assign axi.arsize  = {1'b0, r_size};
  assign axi.arburst = 2'b01;
  assign axi.arlock  = 2'b00;
  assign axi.arcache = 4'd0;
  assign axi.arprot  = 3'd0;
  assign axi.awid    = DATA_ID;
  assign axi.awaddr  = r_addr;
  assign axi.awlen   = 8'd0;
  assign axi.awsize  = {1'b0, r_size};
  assign axi.awburst = 2'b01;
  assign axi.awlock  = 2'b00;
  assign axi.awcache = 4'd0;
  assign axi.awprot  = 3'd0;
  assign axi.wid     = DATA_ID;
  assign axi.wdata   = r_wdata;
  assign axi.wstrb   = w_wstrb;
  assign axi.wlast   = 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    axi.arvalid = 1'b0;
    axi.rready  = 1'b0;
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    axi.bready  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (data_cache_req && !r_done_d)
          w_next = data_cache_wr ? S_D_AWW : S_D_AR;
        else if (inst_cache_req && !r_done_i)
          w_next = S_I_AR;
      end
      S_I_AR, S_D_AR: begin
        axi.arvalid = 1'b1;
        if (axi.arready) w_next = (r_state == S_I_AR) ? S_I_R : S_D_R;
      end
      S_I_R, S_D_R: begin
        axi.rready = 1'b1;
        if (axi.rvalid) w_next = S_IDLE;
      end
      S_D_AWW: begin
        // AW and W complete independently; leave once both have.
        axi.awvalid = ~r_aw_done;
        axi.wvalid  = ~r_w_done;
        if ((r_aw_done || axi.awready) && (r_w_done || axi.wready))
          w_next = S_D_B;
      end
      S_D_B: begin
        axi.bready = 1'b1;
        if (axi.bvalid) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr       <= '0;
      r_wdata      <= '0;
      r_size       <= '0;
      r_done_i     <= 1'b0;
      r_done_d     <= 1'b0;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
      r_inst_dok   <= 1'b0;
      r_data_dok   <= 1'b0;
      r_inst_rdata <= '0;
      r_data_rdata <= '0;
    end else begin
      r_inst_dok <= (r_state == S_I_R) && axi.rvalid;
      r_data_dok <= ((r_state == S_D_R) && axi.rvalid) ||
                    ((r_state == S_D_B) && axi.bvalid);

      if (r_state == S_I_R && axi.rvalid) r_inst_rdata <= axi.rdata;
      if (r_state == S_D_R && axi.rvalid) r_data_rdata <= axi.rdata;

      // Clear when nothing is pending; a completion in the same cycle wins.
      if (!w_stall) begin
        r_done_i <= 1'b0;
        r_done_d <= 1'b0;
      end
      if (r_state == S_I_R && axi.rvalid) r_done_i <= 1'b1;
      if ((r_state == S_D_R && axi.rvalid) || (r_state == S_D_B && axi.bvalid))
        r_done_d <= 1'b1;

      // Request fields are frozen for the whole transaction.
      if (r_state == S_IDLE && w_next != S_IDLE) begin
        if (w_next == S_I_AR) begin
          r_addr  <= inst_cache_addr;
          r_size  <= inst_cache_size;
          r_wdata <= '0;
        end else begin
          r_addr  <= data_cache_addr;
          r_size  <= data_cache_size;
          r_wdata <= data_cache_wdata;
        end
      end

      if (r_state == S_IDLE) begin
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end else if (r_state == S_D_AWW) begin
        if (axi.awready) r_aw_done <= 1'b1;
        if (axi.wready)  r_w_done  <= 1'b1;
      end
    end
  end

endmodule

// File: doc/axi_interface_arbitrater.md
Name: axi_interface_arbitrater

Overview:
- Single-port AXI3/AXI4 master that arbitrates the instruction-cache and data-cache miss/uncached request channels onto one AXI bus.
- Sits directly downstream of the cache wrapper and consumes its req/addr/wr/size/wdata lines.
- Returns rdata and a one-cycle dok pulse to each cache side, plus a pipeline stall.
- Single-beat transfers only (len=0); one outstanding transaction at a time.

Parameters:
- INST_ID, 4'd0, ARID driven for instruction reads.
- DATA_ID, 4'd1, ARID/AWID/WID driven for data transactions.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- stall_by_arbitrater  out  1  pipeline stall while any request is unserved
- inst_cache_req  in  1  instruction request, level, held until served
- inst_cache_addr  in  32  instruction byte address
- inst_cache_wr  in  1  always 0 (ignored)
- inst_cache_size  in  2  transfer size
- inst_cache_wdata  in  32  ignored
- inst_cache_rdata  out  32  read data, valid with dok
- inst_cache_dok  out  1  one-cycle completion pulse
- data_cache_req  in  1  data request, level
- data_cache_addr  in  32  data byte address
- data_cache_wr  in  1  1 = write
- data_cache_size  in  2  00 byte, 01 half, 10 word
- data_cache_wdata  in  32  write data, lane-aligned
- data_cache_rdata  out  32  read data
- data_cache_dok  out  1  completion pulse (reads and writes)
- arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid  out  4/32/8/3/2/2/4/3/1  AR channel
- arready  in  1
- rid/rdata/rresp/rlast/rvalid  in  4/32/2/1/1 ; rready  out  1
- awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awvalid  out  4/32/8/3/2/2/4/3/1  AW channel
- awready  in  1
- wid/wdata/wstrb/wlast/wvalid  out  4/32/4/1/1 ; wready  in  1
- bid/bresp/bvalid  in  4/2/1 ; bready  out  1

Behaviour:
- Reset (async, high): state=IDLE. All valid/ready outputs 0. dok outputs 0, rdata outputs 0, done flags 0.
- Constants:
  - len=0, burst=01, lock=0, cache=0, prot=0, wlast=1.
  - arsize/awsize = {1'b0, size}.
- States: IDLE, I_AR, I_R, D_AR, D_R, D_AWW, D_B.
- IDLE arbitration, data has priority:
  - data_req & ~done_d & wr → D_AWW.
  - data_req & ~done_d & ~wr → D_AR.
  - else inst_req & ~done_i → I_AR.
  - Addr/size/wdata are latched on leaving IDLE and held constant through the transaction.
- I_AR/D_AR: arvalid=1 until arready, then move to I_R/D_R.
- I_R/D_R:
  - rready=1.
  - On rvalid: latch rdata into the matching *_cache_rdata, pulse the matching dok next cycle, set the done flag, return to IDLE.
  - rresp is ignored.
- D_AWW:
  - awvalid and wvalid are both asserted; each drops independently on its own ready.
  - Move to D_B when both handshakes have completed (same cycle or different cycles).
- wstrb:
  - size 00: 4'b0001 << addr[1:0].
  - size 01: 4'b0011 << {addr[1],1'b0}.
  - size 10: 4'b1111.
- D_B: bready=1. On bvalid: pulse data_cache_dok, set done_d, return to IDLE.
- dok: exactly one cycle per transaction, registered. *_rdata holds its value until the next read completes.
- stall_by_arbitrater is combinational:
  - stall = (inst_req & ~done_i) | (data_req & ~done_d).
  - done_i/done_d are set in the cycle the respective dok goes high, so stall drops in the cycle of the final dok.
  - When stall=0, both done flags clear on the next edge, so a new request is accepted next cycle.
- Simultaneous inst+data requests: data is served first, then instruction. stall stays high across both transactions; data dok comes first.
- Minimum read latency with immediate ready: IDLE→AR→R→IDLE, dok 3 cycles after req.
- A req dropping mid-transaction does not abort it: the bus transaction completes and the dok is still issued.
- Reset mid-transaction: the bus is abandoned immediately. The interconnect must also be reset.

Test Plan:
- Inst read, addr 0xBFC0_0000, arready=1, rvalid next cycle, rdata=0x2408_0001:
  - inst_cache_rdata=0x2408_0001.
  - dok is a 1-cycle pulse.
  - stall falls in the dok cycle.
- Data byte write, addr 0x8000_0003, size 00, wdata 0xAB00_0000:
  - awsize=000, wstrb=1000, wid=DATA_ID.
  - data_cache_dok after bvalid.
- Both reqs asserted in the same cycle:
  - data AR issued first, then inst AR.
  - two dok pulses in order.
  - stall held high until inst dok.
- wready arrives 3 cycles after awready:
  - wvalid held until wready.
  - D_B entered only after both handshakes.
- Halfword write, addr 0x...2:
  - wstrb=1100, awsize=001.
- Reset asserted during I_R:
  - all valids/readies and dok go 0 immediately; state=IDLE.
  - no spurious dok after reset release.
